ppu_bus_arbiter: RTL and testbench

- Shares the single-port PPU bus (nametable VRAM plus cartridge CHR, registered read data) between two requesters.
  - The render fetch engine: tile, attribute and pattern fetches.
  - The CPU PPUDATA path: $2007 reads and writes.
- Render fetches have priority. A CPU access waits in a one-entry pending slot and is issued in the first free bus cycle; a starvation counter forces issue if no free cycle appears.
- Also generates the VRAM chip select and the nametable A10 line from the cartridge mirroring mode.

---
 rtl/ppu_bus_arbiter.sv | 209 ++++++++++++++++++++
 tb/tb_ppu_bus_arbiter.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ppu_bus_arbiter.sv
// ---------------------------------------------------------------------------
// ppu_bus_arbiter
//
// Shares the single-port PPU bus (nametable VRAM plus cartridge CHR) between
// the render fetch engine and the CPU PPUDATA ($2007) path. Render fetches
// win the bus whenever they ask for it. A CPU access is parked in a one-entry
// pending slot and goes out in the first cycle the renderer leaves free. A
// starvation counter forces it out if no free cycle shows up in time. The
// block also derives the VRAM chip select and the mirrored nametable A10.
//
// Ports
//   clk, rst_n            clock, synchronous active-low reset
//   mirror_mode           0 horiz, 1 vert, 2 single lower, 3 single upper
//   rend_req/addr         render fetch request (read only) and address
//   rend_gnt              render fetch issued this cycle (combinational)
//   rend_rvalid/rdata     render read data, one cycle after the grant
//   cpu_req/we/addr/wdata CPU access request pulse and its attributes
//   cpu_busy              CPU access pending
//   cpu_done              one-cycle completion pulse
//   cpu_rdata             CPU read buffer
//   bus_*                 shared bus; bus_rdata is registered by the memory
// ---------------------------------------------------------------------------
module ppu_bus_arbiter #(
    parameter int ADDR_W     = 14,
    parameter int STARVE_MAX = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        mirror_mode,
    input  logic              rend_req,
    input  logic [ADDR_W-1:0] rend_addr,
    output logic              rend_gnt,
    output logic              rend_rvalid,
    output logic [7:0]        rend_rdata,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [7:0]        cpu_wdata,
    output logic              cpu_busy,
    output logic              cpu_done,
    output logic [7:0]        cpu_rdata,
    output logic [ADDR_W-1:0] bus_addr,
    output logic              bus_rd,
    output logic              bus_wr,
    output logic              bus_vram_cs,
    output logic              bus_vram_a10,
    output logic [7:0]        bus_wdata,
    input  logic [7:0]        bus_rdata
);

    localparam int CNT_W = $clog2(STARVE_MAX) + 1;
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STARVE_MAX - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PEND = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    state_t              state_r;
    logic [CNT_W-1:0]    starve_cnt_r;
    logic                cpu_we_r;
    logic [ADDR_W-1:0]   cpu_addr_r;
    logic [7:0]          cpu_wdata_r;
    logic [ADDR_W-1:0]   addr_hold_r;
    logic                cpu_busy_r;
    logic                cpu_done_r;
    logic                rend_rvalid_r;
    logic [7:0]          cpu_rdata_r;

    logic                cpu_issue_s;
    logic                rend_gnt_s;
    logic [ADDR_W-1:0]   addr_s;
    logic                rd_s;
    logic                wr_s;

    // Nametable A10 from the cartridge mirroring mode.
    function automatic logic mirror_a10(input logic [1:0] mode,
                                        input logic [ADDR_W-1:0] addr);
        logic a10;
        case (mode)
            2'd0:    a10 = addr[11];
            2'd1:    a10 = addr[10];
            2'd2:    a10 = 1'b0;
            2'd3:    a10 = 1'b1;
            default: a10 = 1'b0;
        endcase
        return a10;
    endfunction

    // Per-cycle winner selection and bus drive.
    always_comb begin
        cpu_issue_s = 1'b0;
        if (state_r == ST_PEND) begin
            // Pending CPU goes out on a free cycle or when its wait is used up.
            cpu_issue_s = !rend_req || (starve_cnt_r == CNT_LAST);
        end else begin
            cpu_issue_s = 1'b0;
        end
        rend_gnt_s = rend_req & ~cpu_issue_s;

        addr_s = addr_hold_r;
        rd_s   = 1'b0;
        wr_s   = 1'b0;
        if (rend_gnt_s) begin
            addr_s = rend_addr;
            rd_s   = 1'b1;
            wr_s   = 1'b0;
        end else if (cpu_issue_s) begin
            addr_s = cpu_addr_r;
            rd_s   = ~cpu_we_r;
            wr_s   = cpu_we_r;
        end else begin
            // Idle bus keeps the previous address to avoid needless toggling.
            addr_s = addr_hold_r;
            rd_s   = 1'b0;
            wr_s   = 1'b0;
        end
    end

    // Arbitration state machine, CPU latch, read buffer and render valid.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r       <= ST_IDLE;
            starve_cnt_r  <= CNT_ZERO;
            cpu_we_r      <= 1'b0;
            cpu_addr_r    <= {ADDR_W{1'b0}};
            cpu_wdata_r   <= 8'h00;
            addr_hold_r   <= {ADDR_W{1'b0}};
            cpu_busy_r    <= 1'b0;
            cpu_done_r    <= 1'b0;
            rend_rvalid_r <= 1'b0;
            cpu_rdata_r   <= 8'h00;
        end else begin
            rend_rvalid_r <= rend_gnt_s;
            if (rend_gnt_s || cpu_issue_s) begin
                addr_hold_r <= addr_s;
            end

            case (state_r)
                ST_IDLE: begin
                    cpu_done_r <= 1'b0;
                    if (cpu_req) begin
                        cpu_we_r    <= cpu_we;
                        cpu_addr_r  <= cpu_addr;
                        cpu_wdata_r <= cpu_wdata;
                        cpu_busy_r  <= 1'b1;
                        state_r     <= ST_PEND;
                    end else begin
                        state_r     <= ST_IDLE;
                    end
                end
                ST_PEND: begin
                    // New requests are ignored here: the slot holds one entry.
                    if (cpu_issue_s) begin
                        cpu_busy_r <= 1'b0;
                        cpu_done_r <= 1'b1;
                        state_r    <= ST_WAIT;
                    end else begin
                        cpu_done_r <= 1'b0;
                        if (starve_cnt_r != CNT_LAST) begin
                            starve_cnt_r <= starve_cnt_r + CNT_ONE;
                        end
                    end
                end
                ST_WAIT: begin
                    // Registered bus data for the access issued last cycle.
                    cpu_done_r   <= 1'b0;
                    starve_cnt_r <= CNT_ZERO;
                    if (!cpu_we_r) begin
                        cpu_rdata_r <= bus_rdata;
                    end
                    if (cpu_req) begin
                        cpu_we_r    <= cpu_we;
                        cpu_addr_r  <= cpu_addr;
                        cpu_wdata_r <= cpu_wdata;
                        cpu_busy_r  <= 1'b1;
                        state_r     <= ST_PEND;
                    end else begin
                        state_r     <= ST_IDLE;
                    end
                end
                default: begin
                    state_r      <= ST_IDLE;
                    starve_cnt_r <= CNT_ZERO;
                    cpu_busy_r   <= 1'b0;
                    cpu_done_r   <= 1'b0;
                end
            endcase
        end
    end

    assign rend_gnt     = rend_gnt_s;
    assign rend_rvalid  = rend_rvalid_r;
    assign rend_rdata   = bus_rdata;
    assign cpu_busy     = cpu_busy_r;
    assign cpu_done     = cpu_done_r;
    assign cpu_rdata    = cpu_rdata_r;
    assign bus_addr     = addr_s;
    assign bus_rd       = rd_s;
    assign bus_wr       = wr_s;
    assign bus_wdata    = cpu_wdata_r;
    // $3F00-$3FFF is not special-cased: it reaches the bus as a nametable read.
    assign bus_vram_cs  = addr_s[13] & (rd_s | wr_s);
    assign bus_vram_a10 = mirror_a10(mirror_mode, addr_s);

endmodule

// File: tb/tb_ppu_bus_arbiter.sv
// Directed bench for ppu_bus_arbiter with a registered-read bus memory model
// and scoreboards for render read data and the CPU read buffer.
module tb_ppu_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  mirror_mode;
    logic        rend_req;
    logic [13:0] rend_addr;
    logic        rend_gnt;
    logic        rend_rvalid;
    logic [7:0]  rend_rdata;
    logic        cpu_req;
    logic        cpu_we;
    logic [13:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        cpu_busy;
    logic        cpu_done;
    logic [7:0]  cpu_rdata;
    logic [13:0] bus_addr;
    logic        bus_rd;
    logic        bus_wr;
    logic        bus_vram_cs;
    logic        bus_vram_a10;
    logic [7:0]  bus_wdata;
    logic [7:0]  bus_rdata;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;

    logic [7:0]  mem [16384];
    logic [13:0] last_wr_addr = 14'h0000;
    logic [7:0]  last_wr_data = 8'h00;

    logic [7:0]  rend_q [$];
    logic [7:0]  cpu_q  [$];
    logic        cpu_chk_next = 1'b0;
    logic [7:0]  cpu_exp_pend = 8'h00;

    ppu_bus_arbiter #(.ADDR_W(14), .STARVE_MAX(8)) dut (
        .clk(clk), .rst_n(rst_n), .mirror_mode(mirror_mode),
        .rend_req(rend_req), .rend_addr(rend_addr), .rend_gnt(rend_gnt),
        .rend_rvalid(rend_rvalid), .rend_rdata(rend_rdata),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_busy(cpu_busy), .cpu_done(cpu_done),
        .cpu_rdata(cpu_rdata), .bus_addr(bus_addr), .bus_rd(bus_rd),
        .bus_wr(bus_wr), .bus_vram_cs(bus_vram_cs), .bus_vram_a10(bus_vram_a10),
        .bus_wdata(bus_wdata), .bus_rdata(bus_rdata)
    );

    always #5 clk = ~clk;

    // Bus memory: registered read data, writes are logged.
    always @(posedge clk) begin
        if (bus_rd) bus_rdata <= mem[bus_addr];
        if (bus_wr) begin
            last_wr_addr <= bus_addr;
            last_wr_data <= bus_wdata;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard monitors, sampled on the falling edge.
    always @(negedge clk) begin
        if (rend_rvalid) begin
            if (rend_q.size() == 0) begin
                check("rend_unexpected_rvalid", 32'd1, 32'd0);
            end else begin
                check("rend_sb_data", {24'd0, rend_rdata}, {24'd0, rend_q.pop_front()});
            end
        end
        if (rend_gnt) rend_q.push_back(mem[rend_addr]);

        if (cpu_chk_next) begin
            check("cpu_sb_rdata", {24'd0, cpu_rdata}, {24'd0, cpu_exp_pend});
            cpu_chk_next = 1'b0;
        end
        if (cpu_done) begin
            done_cnt++;
            if (cpu_q.size() == 0) begin
                check("cpu_unexpected_done", 32'd1, 32'd0);
            end else begin
                cpu_exp_pend = cpu_q.pop_front();
                cpu_chk_next = 1'b1;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic neg();
        @(negedge clk);
    endtask

    logic [13:0] rd_addr_t [8];
    logic [1:0]  rd_mode_t [8];
    logic        rd_a10_t  [8];
    logic [7:0]  rd_data_t [8];
    logic [7:0]  stream_t  [4];
    int          done_before;

    initial begin
        for (int i = 0; i < 16384; i++) mem[i] = 8'(i) ^ 8'h5A;
        mem[14'h2400] = 8'h3C;
        mem[14'h2800] = 8'hC3;
        mem[14'h0100] = 8'h77;
        mem[14'h0010] = 8'h11;
        mem[14'h0011] = 8'h22;
        mem[14'h0012] = 8'h33;
        mem[14'h0013] = 8'h44;
        stream_t = '{8'h11, 8'h22, 8'h33, 8'h44};
        for (int m = 0; m < 4; m++) begin
            rd_addr_t[m]     = 14'h2400; rd_mode_t[m]     = 2'(m); rd_data_t[m]     = 8'h3C;
            rd_addr_t[m + 4] = 14'h2800; rd_mode_t[m + 4] = 2'(m); rd_data_t[m + 4] = 8'hC3;
        end
        rd_a10_t = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};

        rst_n = 1'b0; mirror_mode = 2'd1; rend_req = 1'b0; rend_addr = 14'h0000;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 14'h0000; cpu_wdata = 8'h00;
        step(); step();
        rst_n = 1'b1;
        neg();
        check("rst_busy", {31'd0, cpu_busy}, 32'd0);
        check("rst_done", {31'd0, cpu_done}, 32'd0);
        check("rst_rvalid", {31'd0, rend_rvalid}, 32'd0);
        check("rst_rdata", {24'd0, cpu_rdata}, 32'd0);
        check("rst_bus_rd", {31'd0, bus_rd}, 32'd0);
        check("rst_bus_wr", {31'd0, bus_wr}, 32'd0);

        // Idle CPU write.
        step();
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 14'h2005; cpu_wdata = 8'hA5;
        cpu_q.push_back(8'h00);
        neg();
        check("wr_req_cycle_bus_wr", {31'd0, bus_wr}, 32'd0);
        step();
        cpu_req = 1'b0;
        neg();
        check("wr_bus_wr", {31'd0, bus_wr}, 32'd1);
        check("wr_bus_addr", {18'd0, bus_addr}, 32'h2005);
        check("wr_cs", {31'd0, bus_vram_cs}, 32'd1);
        check("wr_wdata", {24'd0, bus_wdata}, 32'hA5);
        check("wr_busy", {31'd0, cpu_busy}, 32'd1);
        step();
        neg();
        check("wr_done", {31'd0, cpu_done}, 32'd1);
        check("wr_busy_in_wait", {31'd0, cpu_busy}, 32'd0);
        check("wr_bus_wr_off", {31'd0, bus_wr}, 32'd0);
        step();
        neg();
        check("wr_logged_addr", {18'd0, last_wr_addr}, 32'h2005);
        check("wr_logged_data", {24'd0, last_wr_data}, 32'hA5);
        check("wr_done_pulse", {31'd0, cpu_done}, 32'd0);

        // CPU reads across mirroring modes.
        for (int k = 0; k < 8; k++) begin
            step();
            mirror_mode = rd_mode_t[k];
            cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = rd_addr_t[k];
            cpu_q.push_back(rd_data_t[k]);
            step();
            cpu_req = 1'b0;
            neg();
            check("rd_bus_rd", {31'd0, bus_rd}, 32'd1);
            check("rd_bus_addr", {18'd0, bus_addr}, {18'd0, rd_addr_t[k]});
            check("rd_a10", {31'd0, bus_vram_a10}, {31'd0, rd_a10_t[k]});
            check("rd_cs", {31'd0, bus_vram_cs}, 32'd1);
            step();
            neg();
            check("rd_done", {31'd0, cpu_done}, 32'd1);
        end
        step();
        mirror_mode = 2'd1;

        // Render priority with forced CPU issue.
        rend_req = 1'b1; rend_addr = 14'h0100;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 14'h2400;
        cpu_q.push_back(8'h3C);
        neg();
        check("prio_gnt_c0", {31'd0, rend_gnt}, 32'd1);
        for (int c = 1; c < 8; c++) begin
            step();
            cpu_req = 1'b0;
            neg();
            check("prio_gnt", {31'd0, rend_gnt}, 32'd1);
            check("prio_busy", {31'd0, cpu_busy}, 32'd1);
        end
        step();
        neg();
        check("prio_gnt_c8", {31'd0, rend_gnt}, 32'd0);
        check("prio_cpu_rd_c8", {31'd0, bus_rd}, 32'd1);
        check("prio_addr_c8", {18'd0, bus_addr}, 32'h2400);
        check("prio_done_c8", {31'd0, cpu_done}, 32'd0);
        step();
        neg();
        check("prio_done_c9", {31'd0, cpu_done}, 32'd1);
        check("prio_rvalid_gap", {31'd0, rend_rvalid}, 32'd0);
        check("prio_gnt_c9", {31'd0, rend_gnt}, 32'd1);
        step();
        rend_req = 1'b0;
        neg();
        check("prio_rvalid_c10", {31'd0, rend_rvalid}, 32'd1);
        step();
        step();

        // Render stream.
        for (int k = 0; k < 4; k++) begin
            rend_req = 1'b1; rend_addr = 14'h0010 + 14'(k);
            neg();
            check("stream_gnt", {31'd0, rend_gnt}, 32'd1);
            if (k > 0) begin
                check("stream_rvalid", {31'd0, rend_rvalid}, 32'd1);
                check("stream_data", {24'd0, rend_rdata}, {24'd0, stream_t[k - 1]});
            end
            step();
        end
        rend_req = 1'b0;
        neg();
        check("stream_rvalid_last", {31'd0, rend_rvalid}, 32'd1);
        check("stream_data_last", {24'd0, rend_rdata}, {24'd0, stream_t[3]});
        step();
        neg();
        check("stream_rvalid_end", {31'd0, rend_rvalid}, 32'd0);

        // Busy rejection.
        step();
        done_before = done_cnt;
        rend_req = 1'b1; rend_addr = 14'h0010;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 14'h2400;
        cpu_q.push_back(8'h3C);
        step();
        cpu_we = 1'b1; cpu_addr = 14'h2100; cpu_wdata = 8'hEE;
        step();
        cpu_req = 1'b0; rend_req = 1'b0;
        neg();
        check("rej_addr", {18'd0, bus_addr}, 32'h2400);
        check("rej_rd", {31'd0, bus_rd}, 32'd1);
        check("rej_wr", {31'd0, bus_wr}, 32'd0);
        for (int c = 0; c < 5; c++) step();
        neg();
        check("rej_done_count", done_cnt - done_before, 32'd1);
        check("rej_no_write", {18'd0, last_wr_addr}, 32'h2005);

        // Reset in the middle of a pending write.
        step();
        rend_req = 1'b1; rend_addr = 14'h0100;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 14'h2006; cpu_wdata = 8'h99;
        step();
        cpu_req = 1'b0;
        neg();
        check("mid_busy", {31'd0, cpu_busy}, 32'd1);
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1; rend_req = 1'b0;
        cpu_q.delete();
        rend_q.delete();
        cpu_chk_next = 1'b0;
        done_before = done_cnt;
        neg();
        check("mid_rst_busy", {31'd0, cpu_busy}, 32'd0);
        check("mid_rst_done", {31'd0, cpu_done}, 32'd0);
        check("mid_rst_rdata", {24'd0, cpu_rdata}, 32'd0);
        for (int c = 0; c < 4; c++) begin
            step();
            neg();
            check("mid_no_bus_wr", {31'd0, bus_wr}, 32'd0);
        end
        check("mid_no_done", done_cnt - done_before, 32'd0);
        check("mid_no_write_log", {18'd0, last_wr_addr}, 32'h2005);
        check("sb_cpu_empty", cpu_q.size(), 32'd0);
        check("sb_rend_empty", rend_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
